// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first onto a ccff configuration chain and
// gates the chain clock so it only shifts when a valid bit is on ccff_head.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              check_en,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  shift_count
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int SR_W   = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] NW_C     = CNT_W'(NWORDS);
  localparam logic [SR_W-1:0]  REFILL_C = SR_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [SR_W-1:0]     sr_cnt_q, sr_cnt_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    accepted_q, accepted_d;
  logic                check_q, check_d;

  logic                bs_ready_d, ccff_head_d, chain_clk_en_d;
  logic                busy_d, done_d, error_d;
  logic [CNT_W-1:0]    shift_count_d;

  // NOTE: every state element uses <= so all registers update together from
  // the pre-edge values; buffer/shift data are reset too so no X reaches ccff_head.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      sr_q         <= '0;
      sr_cnt_q     <= '0;
      issued_q     <= '0;
      accepted_q   <= '0;
      check_q      <= 1'b0;
      bs_ready     <= 1'b0;
      ccff_head    <= 1'b0;
      chain_clk_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      shift_count  <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      sr_q         <= sr_d;
      sr_cnt_q     <= sr_cnt_d;
      issued_q     <= issued_d;
      accepted_q   <= accepted_d;
      check_q      <= check_d;
      bs_ready     <= bs_ready_d;
      ccff_head    <= ccff_head_d;
      chain_clk_en <= chain_clk_en_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      shift_count  <= shift_count_d;
    end
  end

  // NOTE: every signal gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    buf_full_d     = buf_full_q;
    sr_d           = sr_q;
    sr_cnt_d       = sr_cnt_q;
    issued_d       = issued_q;
    accepted_d     = accepted_q;
    check_d        = check_q;
    ccff_head_d    = ccff_head;
    chain_clk_en_d = chain_clk_en;
    busy_d         = busy;
    done_d         = done;
    error_d        = error;
    shift_count_d  = shift_count;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d        = LOAD;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          shift_count_d  = '0;
          check_d        = check_en;
          chain_clk_en_d = 1'b0;
          buf_full_d     = 1'b0;
          sr_cnt_d       = '0;
          issued_d       = '0;
          accepted_d     = '0;
        end
      end
      LOAD: begin
        chain_clk_en_d = 1'b0;
        // chain_clk_en high at this edge means the chain shifts right now.
        if (chain_clk_en) begin
          shift_count_d = shift_count + CNT_W'(1);
          if (check_q && ccff_tail) error_d = 1'b1;
        end
        if (chain_clk_en && shift_count == LAST_C) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          // Bits beyond CHAIN_LEN (low bits of the last word) are never issued.
          if (issued_q != LEN_C) begin
            if (sr_cnt_q != '0) begin
              ccff_head_d    = sr_q[WORD_W-1];
              sr_d           = sr_q << 1;
              sr_cnt_d       = sr_cnt_q - SR_W'(1);
              issued_d       = issued_q + CNT_W'(1);
              chain_clk_en_d = 1'b1;
            end else if (buf_full_q) begin
              ccff_head_d    = buf_q[WORD_W-1];
              sr_d           = buf_q << 1;
              sr_cnt_d       = REFILL_C;
              buf_full_d     = 1'b0;
              issued_d       = issued_q + CNT_W'(1);
              chain_clk_en_d = 1'b1;
            end
          end
          if (bs_valid && bs_ready) begin
            buf_d      = bs_data;
            buf_full_d = 1'b1;
            accepted_d = accepted_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    bs_ready_d = busy_d && !buf_full_d && (accepted_d < NW_C);
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: chain models on two instances (48/8 and 20/8),
// a per-cycle bit-stream scoreboard on the 48-bit instance, directed and random loads.
module tb_ccff_chain_loader;

  localparam int L   = 48;
  localparam int W   = 8;
  localparam int NWA = 6;
  localparam int LB  = 20;
  localparam logic [47:0] WORDS = 48'hA53CFF00817E;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;
  logic pReset;

  logic        start_a, check_a, valid_a, ready_a, head_a, cen_a, tail_a;
  logic        busy_a, done_a, err_a;
  logic [7:0]  data_a;
  logic [15:0] cnt_a;
  logic [L-1:0] chain_a, preload_a;
  logic        do_pre_a;

  logic        start_b, check_b, valid_b, ready_b, head_b, cen_b, tail_b;
  logic        busy_b, done_b, err_b;
  logic [7:0]  data_b;
  logic [15:0] cnt_b;
  logic [LB-1:0] chain_b;

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(16)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .check_en(check_a),
    .bs_data(data_a), .bs_valid(valid_a), .bs_ready(ready_a), .ccff_head(head_a),
    .chain_clk_en(cen_a), .ccff_tail(tail_a), .busy(busy_a), .done(done_a),
    .error(err_a), .shift_count(cnt_a));

  ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(W), .CNT_W(16)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .check_en(check_b),
    .bs_data(data_b), .bs_valid(valid_b), .bs_ready(ready_b), .ccff_head(head_b),
    .chain_clk_en(cen_b), .ccff_tail(tail_b), .busy(busy_b), .done(done_b),
    .error(err_b), .shift_count(cnt_b));

  // Chain models: bit 0 is the head flop, the top bit drives ccff_tail.
  assign tail_a = chain_a[L-1];
  assign tail_b = chain_b[LB-1];

  always @(posedge prog_clk or posedge pReset) begin
    if (pReset)        chain_a <= '0;
    else if (do_pre_a) chain_a <= preload_a;
    else if (cen_a)    chain_a <= {chain_a[L-2:0], head_a};
  end

  always @(posedge prog_clk or posedge pReset) begin
    if (pReset)     chain_b <= '0;
    else if (cen_b) chain_b <= {chain_b[LB-2:0], head_b};
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  int edge_n = 0;
  always @(posedge prog_clk) edge_n <= edge_n + 1;

  // Scoreboard for dut_a: each accepted word contributes its bits MSB-first
  // (truncated at L total); each bit must be on ccff_head, clock enabled, two
  // cycles after acceptance or as soon as earlier bits have drained.
  bit   m_active, m_done, m_err, m_check, prev_ok;
  int   m_shifts, m_words, m_bits, hs_a, ncyc, s_edge, first_sh, last_sh;
  logic prev_head;
  bit   exp_bit[$];
  int   exp_rdy[$];

  always @(negedge prog_clk) begin
    if (pReset) begin
      m_active = 0; m_done = 0; m_err = 0; m_check = 0; prev_ok = 0;
      m_shifts = 0; m_words = 0; m_bits = 0; hs_a = 0;
      exp_bit.delete(); exp_rdy.delete();
    end else begin
      bit exp_cen;
      ncyc++;
      chk("busy", busy_a, m_active);
      chk("done", done_a, m_done);
      chk("error", err_a, m_err);
      chk("shift_count", cnt_a, m_shifts);
      if (!m_active || m_words == NWA) chk("bs_ready_closed", ready_a, 0);
      exp_cen = m_active && exp_bit.size() > 0 && exp_rdy[0] <= ncyc;
      chk("chain_clk_en", cen_a, exp_cen);
      if (cen_a && exp_bit.size() > 0) chk("ccff_head", head_a, exp_bit[0]);
      if (!cen_a && prev_ok) chk("ccff_head_hold", head_a, prev_head);
      prev_head = head_a;
      prev_ok = 1;

      if (start_a && !m_active) begin
        m_active = 1; m_done = 0; m_err = 0; m_check = check_a;
        m_shifts = 0; m_words = 0; m_bits = 0; hs_a = 0;
        exp_bit.delete(); exp_rdy.delete();
        s_edge = edge_n + 1;
      end else if (m_active) begin
        if (cen_a) begin
          if (exp_bit.size() > 0) begin
            void'(exp_bit.pop_front());
            void'(exp_rdy.pop_front());
          end
          if (m_check && tail_a) m_err = 1;
          if (m_shifts == 0) first_sh = edge_n + 1;
          m_shifts++;
          if (m_shifts == L) begin
            m_active = 0; m_done = 1; last_sh = edge_n + 1;
          end
        end
        if (valid_a && ready_a) begin
          hs_a++;
          m_words++;
          for (int b = W - 1; b >= 0; b--) begin
            if (m_bits < L) begin
              exp_bit.push_back(data_a[b]);
              exp_rdy.push_back(ncyc + 2);
              m_bits++;
            end
          end
        end
      end
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_bs_ready"}, ready_a, 0);
    chk({tag, "_ccff_head"}, head_a, 0);
    chk({tag, "_chain_clk_en"}, cen_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_error"}, err_a, 0);
    chk({tag, "_shift_count"}, cnt_a, 0);
  endtask

  // mode 0: valid held high, 1: valid toggles per cycle, 2: sparse random valid.
  task automatic run_a(input logic [47:0] wp, input int mode, input logic ce,
                       input logic [47:0] pre, input bit mid_start, input int abort_it);
    int idx;
    bit hs, fin;
    idx = 0;
    fin = 0;
    @(posedge prog_clk); #1;
    preload_a = pre;
    do_pre_a = 1;
    @(posedge prog_clk); #1;
    do_pre_a = 0;
    start_a = 1;
    check_a = ce;
    data_a = wp[47 -: 8];
    valid_a = (mode == 2) ? ($urandom_range(0, 4) == 0) : 1'b1;
    @(posedge prog_clk); #1;
    start_a = 0;
    for (int it = 1; it < 1000 && !fin; it++) begin
      @(negedge prog_clk);
      hs = valid_a && ready_a;
      if (done_a) begin
        fin = 1;
      end else if (abort_it > 0 && it == abort_it) begin
        chk("shifts_before_abort", cnt_a, abort_it - 3);
        #2 pReset = 1;
        #1 chk_reset_a("abort");
        @(negedge prog_clk); #1;
        pReset = 0;
        valid_a = 0;
        start_a = 0;
        return;
      end else begin
        @(posedge prog_clk); #1;
        if (hs) idx++;
        data_a = (idx < NWA) ? wp[47 - 8 * idx -: 8] : 8'h5A;
        case (mode)
          0:       valid_a = 1'b1;
          1:       valid_a = (it % 2 == 0);
          default: valid_a = ($urandom_range(0, 4) == 0);
        endcase
        start_a = mid_start && (it == 20);
      end
    end
    if (!fin) chk("load_timeout_a", done_a, 1);
    valid_a = 0;
    start_a = 0;
  endtask

  initial begin
    int idx;
    int hs_b;
    bit fin;
    pReset = 1;
    start_a = 0; check_a = 0; valid_a = 0; data_a = '0;
    start_b = 0; check_b = 0; valid_b = 0; data_b = '0;
    do_pre_a = 0; preload_a = '0;
    #3;
    chk_reset_a("init");
    chk("init_b_busy", busy_b, 0);
    chk("init_b_bs_ready", ready_b, 0);
    @(negedge prog_clk); @(negedge prog_clk); #1;
    pReset = 0;

    // Full stream, valid held high.
    run_a(WORDS, 0, 1, '0, 0, 0);
    chk("t1_chain", chain_a, 48'hA53CFF00817E);
    chk("t1_shift_count", cnt_a, 48);
    chk("t1_done", done_a, 1);
    chk("t1_error", err_a, 0);
    chk("t1_handshakes", hs_a, 6);
    chk("t1_first_shift_edge", first_sh, s_edge + 3);
    chk("t1_last_shift_edge", last_sh, s_edge + 50);

    // Same stream, valid toggling.
    run_a(WORDS, 1, 1, '0, 0, 0);
    chk("t2_chain", chain_a, 48'hA53CFF00817E);
    chk("t2_shift_count", cnt_a, 48);
    chk("t2_done", done_a, 1);

    // Short chain: last word contributes only its top nibble.
    @(posedge prog_clk); #1;
    start_b = 1; check_b = 1; data_b = 8'hFF; valid_b = 1;
    idx = 0; hs_b = 0; fin = 0;
    @(posedge prog_clk); #1;
    start_b = 0;
    for (int it = 0; it < 200 && !fin; it++) begin
      bit hs;
      @(negedge prog_clk);
      hs = valid_b && ready_b;
      if (done_b) fin = 1;
      else begin
        @(posedge prog_clk); #1;
        if (hs) begin
          hs_b++;
          idx++;
        end
        data_b = (idx == 0) ? 8'hFF : (idx == 1) ? 8'h00 : (idx == 2) ? 8'hF3 : 8'hAA;
      end
    end
    if (!fin) chk("load_timeout_b", done_b, 1);
    valid_b = 0;
    chk("t3_handshakes", hs_b, 3);
    chk("t3_shift_count", cnt_b, 20);
    chk("t3_chain", chain_b, 20'hFF00F);
    chk("t3_error", err_b, 0);
    chk("t3_bs_ready", ready_b, 0);

    // A stray 1 inside the chain must be seen at the tail.
    run_a(WORDS, 0, 1, 48'h400, 0, 0);
    chk("t4_error_checked", err_a, 1);
    chk("t4_chain", chain_a, 48'hA53CFF00817E);
    run_a(WORDS, 0, 0, 48'h400, 0, 0);
    chk("t4_error_unchecked", err_a, 0);

    // Abort after 17 shifts, then a clean full load.
    run_a(WORDS, 0, 1, '0, 0, 20);
    chk("t5_done_after_abort", done_a, 0);
    run_a(WORDS, 0, 1, '0, 0, 0);
    chk("t5_shift_count", cnt_a, 48);
    chk("t5_chain", chain_a, 48'hA53CFF00817E);
    chk("t5_done", done_a, 1);

    // Start pulse mid-load plus a 7th word on offer: both ignored.
    run_a(WORDS, 0, 1, '0, 1, 0);
    chk("t6_chain", chain_a, 48'hA53CFF00817E);
    chk("t6_shift_count", cnt_a, 48);
    chk("t6_handshakes", hs_a, 6);

    // Random words, sparse valid, random check_en and preload.
    for (int r = 0; r < 4; r++) begin
      logic [47:0] wp, pre;
      logic ce;
      wp  = {$urandom(), $urandom()};
      pre = ($urandom_range(0, 1) == 1) ? {$urandom(), $urandom()} : 48'h0;
      ce  = $urandom_range(0, 1);
      run_a(wp, 2, ce, pre, 0, 0);
      chk("rnd_chain", chain_a, wp);
      chk("rnd_shift_count", cnt_a, 48);
      chk("rnd_error", err_a, ce && (pre != 0));
      chk("rnd_handshakes", hs_a, 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain driver for the routing fabric. It accepts bitstream words over a valid/ready stream, serializes them MSB-first onto `ccff_head` of a connection-block/switch-block configuration chain, and controls the chain's clock enable so it shifts only when a valid bit is present. It samples the chain's `ccff_tail` on every shift to check that the chain was cleared. It sits between the bitstream source and the first `ccff_head` of a chain of `*_mem` shift registers.

## Interface
Parameters:
- `CHAIN_LEN`, 48: number of configuration flops in the driven chain (≥1), i.e. total shifts per load.
- `WORD_W`, 8: bitstream word width (≥1).
- `CNT_W`, 16: shift-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- `prog_clk`  input  1  configuration clock; sole clock domain.
- `pReset`  input  1  asynchronous, active-high reset. The same net clears the chain flops.
- `start`  input  1  one-cycle request to begin a load. Ignored while `busy`.
- `check_en`  input  1  enables the tail zero-check. Sampled at `start`.
- `bs_data`  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- `bs_valid`  input  1  `bs_data` is valid.
- `bs_ready`  output  1  loader accepts a word this cycle.
- `ccff_head`  output  1  serial data into the chain head.
- `chain_clk_en`  output  1  enable for the chain's prog_clk gate. The chain captures `ccff_head` at each rising edge where this signal is 1.
- `ccff_tail`  input  1  serial output of the chain's last flop.
- `busy`  output  1  load in progress.
- `done`  output  1  level; last load completed. Cleared by `start`.
- `error`  output  1  sticky tail-check failure for the current/last load.
- `shift_count`  output  CNT_W  shifts performed in the current/last load.

## Operation
- A **shift** is a rising edge of `prog_clk` at which the registered `chain_clk_en` is 1. At that edge:
  - the chain captures `ccff_head`;
  - the loader samples `ccff_tail` (pre-shift value) and increments `shift_count`.
- NWORDS = ceil(CHAIN_LEN / WORD_W).
  - The loader accepts exactly NWORDS words per load.
  - In the last word, only the top (CHAIN_LEN − (NWORDS−1)·WORD_W) bits are shifted. The low bits are discarded.
- Datapath:
  - One-word prefetch buffer plus a WORD_W shift register.
  - `bs_ready` = `busy` & buffer empty & words_accepted < NWORDS (registered).
  - A word is accepted on any edge with `bs_valid` & `bs_ready`.
- FSM:
  - **IDLE**: outputs quiescent. On `start`, go to LOAD. On the same edge: `busy`←1, `done`←0, `error`←0, `shift_count`←0, latch `check_en`.
  - **LOAD**: Whenever the shift register has a pending bit, drive it on `ccff_head` with `chain_clk_en`=1. Refill the shift register from the buffer with no bubble. If no bit is pending (source starved), `chain_clk_en`←0 and `ccff_head` holds its value. When the shift that makes `shift_count`=CHAIN_LEN occurs, go to DONE.
  - **DONE**: At the edge of the final shift: `busy`←0, `done`←1, `chain_clk_en`←0, `bs_ready`←0. Stay in DONE until `start`, which behaves as `start` in IDLE.
- Tail check: when latched `check_en`=1, any shift sampling `ccff_tail`=1 sets `error`. `error` is sticky until the next `start` or reset. The chain is expected to be all-zero after `pReset`.
- Words offered after NWORDS are accepted are not consumed (`bs_ready` stays 0).
- A `start` received while `busy` has no effect.

## Timing
- Reset values (asynchronous): `ccff_head`=0, `chain_clk_en`=0, `bs_ready`=0, `busy`=0, `done`=0, `error`=0, `shift_count`=0, FSM=IDLE, buffers empty.
- All outputs are registered on the `prog_clk` rising edge.
- `start` sampled at edge S: `busy`=1 and `bs_ready`=1 after S.
- Word accepted at edge E:
  - its MSB appears on `ccff_head` with `chain_clk_en`=1 after edge E+1;
  - its first shift occurs at edge E+2.
- With `bs_valid` held high, shifts occur on every consecutive edge: S+3 through S+2+CHAIN_LEN. `done` rises after the last shift.
- `pReset` mid-load aborts immediately and returns to reset values. No partial `done` is produced. A new `start` is required.

## Test plan
- CHAIN_LEN=48, WORD_W=8, `bs_valid` held high, words 0xA5,0x3C,0xFF,0x00,0x81,0x7E, `check_en`=1, chain model all-zero:
  - exactly 48 shifts, on edges S+3..S+50;
  - model contents equal the serialized stream MSB-first;
  - `done`=1, `error`=0, `shift_count`=48;
  - exactly 6 handshakes.
- Same stream with `bs_valid` toggled 1-0-1 per cycle:
  - `chain_clk_en` drops while starved and `ccff_head` holds;
  - final chain contents are identical and `shift_count`=48.
- CHAIN_LEN=20, WORD_W=8, words 0xFF,0x00,0xF3:
  - 3 words accepted;
  - last word contributes bits 1111 only; low nibble 0011 is never shifted;
  - `shift_count`=20.
- Chain model preloaded with a single 1 at position 10, `check_en`=1:
  - `error`=1 at `done`.
  - Repeat with `check_en`=0: `error`=0.
- Assert `pReset` after 17 shifts:
  - all outputs return to reset values asynchronously;
  - a subsequent `start` with a full stream completes normally with 48 shifts.
- Pulse `start` mid-load and offer a 7th word: both are ignored, `bs_ready`=0, and the load completes unchanged.
